// File: rtl/vertex_persp_div.sv
// Perspective divide and viewport mapping for one triangle at a time.
// A single 33-step restoring reciprocal divider is shared by the three vertices.
module vertex_persp_div #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_in [3:0],
  input  logic [31:0] y_in [3:0],
  input  logic [31:0] z_in [3:0],
  input  logic [31:0] w_in [3:0],
  input  logic        input_data_valid,
  input  logic        done_in,
  input  logic        stall_in,
  output logic [31:0] sx_out [2:0],
  output logic [31:0] sy_out [2:0],
  output logic [31:0] sz_out [2:0],
  output logic        clipped_out,
  output logic        out_data_valid,
  output logic        done_out,
  output logic        stall_out
);

  localparam logic [31:0] HALF_W = 32'(WIDTH) << 15;
  localparam logic [31:0] HALF_H = 32'(HEIGHT) << 15;

  typedef enum logic [1:0] {IDLE, DIV, MAP, OUT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] x_reg [3];
  logic [31:0] y_reg [3];
  logic [31:0] z_reg [3];
  logic [31:0] w_reg [3];
  logic [31:0] sx_reg [3];
  logic [31:0] sy_reg [3];
  logic [31:0] sz_reg [3];
  logic        clipped_reg;
  logic        done_reg;
  logic [1:0]  vtx_reg;
  logic [5:0]  bit_cnt_reg;
  logic [31:0] rem_reg;
  logic [32:0] quot_reg;

  // Signed Q16.16 multiply: full product, shift right 16, keep low 32 bits.
  // Low 64 bits of the unsigned product of sign-extended operands equal the signed product.
  function automatic logic [31:0] fp_m(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return 32'(p >> 16);
  endfunction

  // Lane 3 of each input bus carries no vertex.
  logic unused_lanes;
  assign unused_lanes = ^{x_in[3], y_in[3], z_in[3], w_in[3]};

  logic [2:0] w_nonpos;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clip
      assign w_nonpos[gi] = $signed(w_in[gi]) <= 32'sd0;
    end
  endgenerate

  // Divider datapath: dividend is 2^32, so only the first step shifts in a one.
  logic [31:0] divisor;
  logic        dividend_bit;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] recip;

  assign divisor      = ($signed(w_reg[vtx_reg]) <= 32'sd0) ? 32'd1 : w_reg[vtx_reg];
  assign dividend_bit = (bit_cnt_reg == 6'd0);
  assign rem_shift    = {rem_reg, dividend_bit};
  assign rem_ge       = rem_shift >= {1'b0, divisor};
  assign rem_next     = rem_ge ? (rem_shift[31:0] - divisor) : rem_shift[31:0];
  assign recip        = (quot_reg[32:31] != 2'b00) ? 32'h7FFF_FFFF : quot_reg[31:0];

  // Viewport mapping for the vertex currently selected by vtx_reg.
  logic [31:0] ndc_x, ndc_y, ndc_z;
  logic [31:0] sx_val, sy_val;

  assign ndc_x  = fp_m(x_reg[vtx_reg], recip);
  assign ndc_y  = fp_m(y_reg[vtx_reg], recip);
  assign ndc_z  = fp_m(z_reg[vtx_reg], recip);
  assign sx_val = fp_m(ndc_x, HALF_W) + HALF_W;
  assign sy_val = HALF_H - fp_m(ndc_y, HALF_H);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (input_data_valid) state_next = DIV;
      DIV:  if (bit_cnt_reg == 6'd32) state_next = MAP;
      MAP:  state_next = (vtx_reg == 2'd2) ? OUT : DIV;
      OUT:  if (!stall_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      clipped_reg <= 1'b0;
      done_reg    <= 1'b0;
      vtx_reg     <= 2'd0;
      bit_cnt_reg <= 6'd0;
      rem_reg     <= 32'd0;
      quot_reg    <= 33'd0;
      for (int i = 0; i < 3; i++) begin
        x_reg[i]  <= 32'd0;
        y_reg[i]  <= 32'd0;
        z_reg[i]  <= 32'd0;
        w_reg[i]  <= 32'd0;
        sx_reg[i] <= 32'd0;
        sy_reg[i] <= 32'd0;
        sz_reg[i] <= 32'd0;
      end
    end else begin
      state_reg <= state_next;
      // Only an idle block with no pending triangle forwards end-of-stream.
      done_reg  <= (state_reg == IDLE) && !input_data_valid && done_in;
      case (state_reg)
        IDLE: begin
          if (input_data_valid) begin
            for (int i = 0; i < 3; i++) begin
              x_reg[i] <= x_in[i];
              y_reg[i] <= y_in[i];
              z_reg[i] <= z_in[i];
              w_reg[i] <= w_in[i];
            end
            clipped_reg <= |w_nonpos;
            vtx_reg     <= 2'd0;
            bit_cnt_reg <= 6'd0;
            rem_reg     <= 32'd0;
            quot_reg    <= 33'd0;
          end
        end
        DIV: begin
          rem_reg     <= rem_next;
          quot_reg    <= {quot_reg[31:0], rem_ge};
          bit_cnt_reg <= bit_cnt_reg + 6'd1;
        end
        MAP: begin
          sx_reg[vtx_reg] <= sx_val;
          sy_reg[vtx_reg] <= sy_val;
          sz_reg[vtx_reg] <= ndc_z;
          vtx_reg         <= vtx_reg + 2'd1;
          bit_cnt_reg     <= 6'd0;
          rem_reg         <= 32'd0;
          quot_reg        <= 33'd0;
        end
        default: ;
      endcase
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_out
      assign sx_out[gi] = clipped_reg ? 32'd0 : sx_reg[gi];
      assign sy_out[gi] = clipped_reg ? 32'd0 : sy_reg[gi];
      assign sz_out[gi] = clipped_reg ? 32'd0 : sz_reg[gi];
    end
  endgenerate

  assign clipped_out    = clipped_reg;
  assign out_data_valid = (state_reg == OUT);
  assign stall_out      = (state_reg != IDLE);
  assign done_out       = done_reg;

endmodule

// File: tb/tb_vertex_persp_div.sv
// Directed bench for vertex_persp_div: expected triangles go into a scoreboard
// queue, and a negedge monitor pops and compares on every output transfer.
module tb_vertex_persp_div;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] x_in [3:0];
  logic [31:0] y_in [3:0];
  logic [31:0] z_in [3:0];
  logic [31:0] w_in [3:0];
  logic        input_data_valid, done_in, stall_in;
  logic [31:0] sx_out [2:0];
  logic [31:0] sy_out [2:0];
  logic [31:0] sz_out [2:0];
  logic        clipped_out, out_data_valid, done_out, stall_out;

  always #5 clock = ~clock;

  vertex_persp_div #(.WIDTH(640), .HEIGHT(480)) dut (
    .clock(clock), .reset(reset),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .w_in(w_in),
    .input_data_valid(input_data_valid), .done_in(done_in), .stall_in(stall_in),
    .sx_out(sx_out), .sy_out(sy_out), .sz_out(sz_out),
    .clipped_out(clipped_out), .out_data_valid(out_data_valid),
    .done_out(done_out), .stall_out(stall_out)
  );

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] MONE = 32'hFFFF_0000;
  localparam logic [31:0] CX   = 32'h0140_0000;  // 320.0
  localparam logic [31:0] CY   = 32'h00F0_0000;  // 240.0
  localparam logic [31:0] Z3   = 32'h0000_0000;

  typedef struct packed {
    logic [2:0][31:0] sx;
    logic [2:0][31:0] sy;
    logic [2:0][31:0] sz;
    logic             clipped;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0, n_xfer = 0, n_push = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [2:0][31:0] vec3(input logic [31:0] v0, input logic [31:0] v1,
                                            input logic [31:0] v2);
    logic [2:0][31:0] r;
    r[0] = v0; r[1] = v1; r[2] = v2;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [2:0][31:0] sx, input logic [2:0][31:0] sy,
                                  input logic [2:0][31:0] sz, input logic clipped);
    exp_t e;
    e.sx = sx; e.sy = sy; e.sz = sz; e.clipped = clipped;
    return e;
  endfunction

  task automatic drive_tri(input logic [2:0][31:0] x, input logic [2:0][31:0] y,
                           input logic [2:0][31:0] z, input logic [2:0][31:0] w);
    for (int i = 0; i < 3; i++) begin
      x_in[i] = x[i]; y_in[i] = y[i]; z_in[i] = z[i]; w_in[i] = w[i];
    end
    x_in[3] = 32'hDEAD_BEEF; y_in[3] = 32'hDEAD_BEEF;
    z_in[3] = 32'hDEAD_BEEF; w_in[3] = 32'h8000_0000;
  endtask

  // Monitor: every cycle with valid and no stall is a transfer.
  always @(negedge clock) begin
    if (!reset && out_data_valid && !stall_in) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got valid=1 expected no transfer");
      end else begin
        mon_e = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          check($sformatf("sx%0d", i), sx_out[i], mon_e.sx[i]);
          check($sformatf("sy%0d", i), sy_out[i], mon_e.sy[i]);
          check($sformatf("sz%0d", i), sz_out[i], mon_e.sz[i]);
        end
        check("clipped", {31'd0, clipped_out}, {31'd0, mon_e.clipped});
        n_xfer++;
        $display("xfer %0d: sx=%08h/%08h/%08h sy=%08h/%08h/%08h sz=%08h/%08h/%08h clipped=%0d",
                 n_xfer, sx_out[0], sx_out[1], sx_out[2], sy_out[0], sy_out[1], sy_out[2],
                 sz_out[0], sz_out[1], sz_out[2], clipped_out);
      end
    end
  end

  // Issue one triangle, check its latency, optionally stall the output for hold cycles.
  task automatic run_tri(input logic [2:0][31:0] x, input logic [2:0][31:0] y,
                         input logic [2:0][31:0] z, input logic [2:0][31:0] w,
                         input exp_t e, input int hold, input string tag);
    int lat;
    drive_tri(x, y, z, w);
    sb_q.push_back(e);
    n_push++;
    stall_in = (hold > 0);
    input_data_valid = 1'b1;
    @(posedge clock); #1;
    input_data_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 50) check({tag, "_done_in_flight"}, {31'd0, done_out}, 32'd0);
      if (out_data_valid) break;
    end
    check({tag, "_latency"}, lat, 32'd102);
    check({tag, "_done_at_out"}, {31'd0, done_out}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, {31'd0, out_data_valid}, 32'd1);
      check({tag, "_hold_stall_out"}, {31'd0, stall_out}, 32'd1);
      check({tag, "_hold_sx1"}, sx_out[1], e.sx[1]);
      check({tag, "_hold_sz0"}, sz_out[0], e.sz[0]);
      @(posedge clock); #1;
      if (i == 1) begin
        drive_tri(vec3(ONE, ONE, ONE), vec3(ONE, ONE, ONE), vec3(ONE, ONE, ONE), vec3(1, 1, 1));
        input_data_valid = 1'b1;
      end
      @(negedge clock);
    end
    if (hold > 0) begin
      @(posedge clock); #1;
      stall_in = 1'b0;
      input_data_valid = 1'b0;
      @(negedge clock);
    end
    @(posedge clock);
    @(negedge clock);
    check({tag, "_after_valid"}, {31'd0, out_data_valid}, 32'd0);
    check({tag, "_after_stall_out"}, {31'd0, stall_out}, 32'd0);
    check({tag, "_after_done"}, {31'd0, done_out}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][31:0] zz;
    logic [2:0][31:0] cx3, cy3;
    zz  = vec3(Z3, Z3, Z3);
    cx3 = vec3(CX, CX, CX);
    cy3 = vec3(CY, CY, CY);

    reset = 1'b1; input_data_valid = 1'b0; done_in = 1'b0; stall_in = 1'b0;
    drive_tri(zz, zz, zz, zz);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", {31'd0, out_data_valid}, 32'd0);
    check("rst_stall_out", {31'd0, stall_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_clipped", {31'd0, clipped_out}, 32'd0);
    check("rst_sx0", sx_out[0], 32'd0);
    check("rst_sy2", sy_out[2], 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Centre of screen for every vertex.
    run_tri(zz, zz, zz, vec3(ONE, ONE, ONE), mk_exp(cx3, cy3, zz, 1'b0), 0, "t1");

    // w=2.0 on v0 gives reciprocal 0.5.
    run_tri(vec3(ONE, 0, 0), vec3(MONE, 0, 0), vec3(32'h8000, 0, 0), vec3(32'h2_0000, ONE, ONE),
            mk_exp(vec3(32'h01E0_0000, CX, CX), vec3(32'h0168_0000, CY, CY),
                   vec3(32'h4000, 0, 0), 1'b0), 0, "t2");

    // w=0 on v1 clips the whole triangle.
    run_tri(vec3(ONE, ONE, ONE), zz, vec3(ONE, ONE, ONE), vec3(ONE, 0, ONE),
            mk_exp(zz, zz, zz, 1'b1), 0, "t3");

    // Tiny w: 1 and 2 saturate, 3 does not.
    run_tri(zz, zz, vec3(ONE, ONE, ONE), vec3(1, 2, 3),
            mk_exp(cx3, cy3, vec3(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h5555_5555), 1'b0), 0, "t4");

    // Screen corners and a reciprocal of 2.0.
    run_tri(vec3(MONE, 32'h8000, 0), vec3(ONE, 0, 0), vec3(32'hFFFF_8000, 0, 0),
            vec3(ONE, 32'h8000, ONE),
            mk_exp(vec3(0, 32'h0280_0000, CX), vec3(0, CY, CY), vec3(32'hFFFF_8000, 0, 0), 1'b0),
            0, "t5");

    // Negative w on v2 clips.
    run_tri(vec3(ONE, ONE, ONE), vec3(ONE, ONE, ONE), zz, vec3(ONE, ONE, MONE),
            mk_exp(zz, zz, zz, 1'b1), 0, "t6");

    // Output held under stall for 10 cycles, extra input ignored.
    run_tri(vec3(ONE, 0, 0), vec3(MONE, 0, 0), vec3(32'h8000, 0, 0), vec3(32'h2_0000, ONE, ONE),
            mk_exp(vec3(32'h01E0_0000, CX, CX), vec3(32'h0168_0000, CY, CY),
                   vec3(32'h4000, 0, 0), 1'b0), 10, "stall");

    // Reset in the middle of a triangle abandons it.
    drive_tri(zz, zz, zz, vec3(ONE, ONE, ONE));
    input_data_valid = 1'b1;
    @(posedge clock); #1;
    input_data_valid = 1'b0;
    repeat (39) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_valid", {31'd0, out_data_valid}, 32'd0);
    check("midrst_stall_out", {31'd0, stall_out}, 32'd0);
    check("midrst_sx1", sx_out[1], 32'd0);
    check("midrst_sy0", sy_out[0], 32'd0);
    repeat (3) @(negedge clock);
    check("midrst_idle_stall_out", {31'd0, stall_out}, 32'd0);
    run_tri(vec3(ONE, 0, 0), vec3(MONE, 0, 0), vec3(32'h8000, 0, 0), vec3(32'h2_0000, ONE, ONE),
            mk_exp(vec3(32'h01E0_0000, CX, CX), vec3(32'h0168_0000, CY, CY),
                   vec3(32'h4000, 0, 0), 1'b0), 0, "postrst");

    // End-of-stream held back until the triangle has left.
    done_in = 1'b1;
    run_tri(zz, zz, zz, vec3(ONE, ONE, ONE), mk_exp(cx3, cy3, zz, 1'b0), 0, "done");
    @(negedge clock);
    check("done_set", {31'd0, done_out}, 32'd1);
    done_in = 1'b0;
    @(negedge clock);
    check("done_clear", {31'd0, done_out}, 32'd0);

    repeat (5) @(negedge clock);
    check("xfer_count", n_xfer, n_push);
    check("queue_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
